muldiv_share_arb: RTL and testbench
===================================

// Module: muldiv_share_arb
// PURPOSE
//  Round-robin arbiter and sequencer sharing one multi-cycle MUL/DIV execute unit between NUM_REQ requesters.
//  - Grants one request, latches its operands and pulses the unit's start.
//  - Waits for the unit's valid pulse, then returns the result to the owning requester.
//  - Sits between the issue lanes and the mul/div unit; one operation in flight at a time.
// PARAMETERS
//  NUM_REQ   2   number of requesters (2..8); ID_W = $clog2(NUM_REQ) is a derived localparam
//  TIMEOUT   64  max WAIT cycles before abort (used only with MULDIV_TIMEOUT_EN)
// PORTS
//  clk          in   1           clock
//  rst_n        in   1           synchronous active-low reset
//  req          in   NUM_REQ     per-requester request; held until req_ready
//  req_op       in   3*NUM_REQ   per-requester op: 0 = mul, otherwise div
//  req_a        in   32*NUM_REQ  per-requester operand a
//  req_b        in   32*NUM_REQ  per-requester operand b
//  req_ready    out  NUM_REQ     one-hot accept pulse (combinational)
//  rsp_valid    out  NUM_REQ     one-hot result pulse, registered
//  rsp_result   out  32          result, valid with rsp_valid
//  rsp_err      out  1           timeout flag, valid with rsp_valid
//  busy         out  1           high in any state other than IDLE
//  unit_start   out  1           one-cycle start pulse to mul/div unit
//  unit_op      out  3           latched op
//  unit_a       out  32          latched operand a
//  unit_b       out  32          latched operand b
//  unit_valid   in   1           one-cycle completion pulse from unit
//  unit_result  in   32          unit result, sampled on unit_valid
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, rr pointer 0. Reset mid-operation abandons the op; no response is issued.
//  FSM states: IDLE, ISSUE, WAIT, RESP, DRAIN (DRAIN exists only with the macro).
//   IDLE -> ISSUE when |req.
//    - Winner: first set bit scanning from pointer upward, wrapping.
//    - req_ready[winner] = 1 this cycle; op/a/b and owner id registered.
//   ISSUE -> WAIT: unit_start = 1 for exactly this one cycle.
//   WAIT -> RESP on unit_valid: unit_result latched into rsp_result.
//   RESP -> IDLE:
//    - rsp_valid[owner] = 1 for one cycle; pointer <= (owner+1) mod NUM_REQ.
//    - No grant is made in RESP; the next grant is possible on the following cycle.
//  Latency: accept at cycle T; unit_start at T+1; rsp_valid one cycle after the unit_valid cycle.
//   Example: mul with 10-cycle unit gives unit_valid at T+11, rsp_valid at T+12.
//  req_ready is 0 whenever busy. A req dropped before grant is never granted.
//  unit_valid outside WAIT is ignored. unit_op/a/b hold until the next grant.
//  Arithmetic is pass-through: div-by-zero and overflow are returned unchanged; rsp_err stays 0.
//  Simultaneous requests with pointer=0 and req=2'b11: grant order is 0, 1, 0, 1, ...
// CONFIGURATION
//  MULDIV_TIMEOUT_EN defined:
//   - 8-bit WAIT counter, cleared on entering WAIT.
//   - If the counter reaches TIMEOUT with no unit_valid, go to RESP with rsp_result=32'hFFFF_FFFF and rsp_err=1.
//   - Then go to DRAIN, which discards the late unit_valid.
//   - Exit DRAIN to IDLE on unit_valid or after TIMEOUT cycles, whichever comes first.
//  MULDIV_TIMEOUT_EN undefined:
//   - No counter and no DRAIN state; WAIT waits indefinitely; rsp_err tied 0.
// TESTING
//  1. req=01, op0=0, a=7, b=6 -> req_ready=01 at T, unit_start at T+1, rsp_valid=01, rsp_result=42.
//  2. req=11 held, both div 100/5 -> grants 0,1,0,1; each rsp_result=20; no back-to-back grants.
//  3. req0 pulsed 1 cycle while busy, then dropped -> never granted, no rsp_valid[0].
//  4. rst_n low 3 cycles during WAIT -> outputs 0, pointer 0; following unit_valid ignored; next req served normally.
//  5. Spurious unit_valid in IDLE and ISSUE -> no rsp_valid; correct result still returned later.
//  6. [MULDIV_TIMEOUT_EN] unit stalled, TIMEOUT=64:
//     - rsp_valid at cycle 64 of WAIT +1 with rsp_err=1, result FFFF_FFFF.
//     - Late unit_valid in DRAIN is dropped.

Source files
------------

// File: rtl/muldiv_share_arb.sv
// Round-robin arbiter/sequencer sharing one multi-cycle MUL/DIV unit between NUM_REQ requesters.
// Optional watchdog on the unit: define MULDIV_TIMEOUT_EN (adds the WAIT counter and DRAIN state).
module muldiv_share_arb #(
   parameter int NUM_REQ = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req,
   input  logic [3*NUM_REQ-1:0]   req_op,
   input  logic [32*NUM_REQ-1:0]  req_a,
   input  logic [32*NUM_REQ-1:0]  req_b,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [NUM_REQ-1:0]     rsp_valid,
   output logic [31:0]            rsp_result,
   output logic                   rsp_err,
   output logic                   busy,
   output logic                   unit_start,
   output logic [2:0]             unit_op,
   output logic [31:0]            unit_a,
   output logic [31:0]            unit_b,
   input  logic                   unit_valid,
   input  logic [31:0]            unit_result
);
   localparam int ID_W = $clog2(NUM_REQ);

   if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_param
      $error("muldiv_share_arb: parameter out of range");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
`ifdef MULDIV_TIMEOUT_EN
      S_DRAIN,
`endif
      S_RESP
   } state_t;

   state_t          state;
   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] owner;
   logic [ID_W-1:0] win;
   logic            found;

   // First pending request at or above the pointer, wrapping around.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (!found && req[(int'(ptr) + i) % NUM_REQ]) begin
            found = 1'b1;
            win   = ID_W'((int'(ptr) + i) % NUM_REQ);
         end
      end
   end

   always_comb begin
      req_ready = '0;
      if (state == S_IDLE && found) req_ready[win] = 1'b1;
   end

   assign busy = (state != S_IDLE);

`ifdef MULDIV_TIMEOUT_EN
   logic [7:0] cnt;
`else
   assign rsp_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         ptr        <= '0;
         owner      <= '0;
         unit_start <= 1'b0;
         unit_op    <= '0;
         unit_a     <= '0;
         unit_b     <= '0;
         rsp_valid  <= '0;
         rsp_result <= '0;
`ifdef MULDIV_TIMEOUT_EN
         rsp_err    <= 1'b0;
         cnt        <= '0;
`endif
      end else begin
         unit_start <= 1'b0;
         rsp_valid  <= '0;
         case (state)
            S_IDLE: begin
               if (found) begin
                  owner      <= win;
                  unit_op    <= req_op[int'(win)*3 +: 3];
                  unit_a     <= req_a[int'(win)*32 +: 32];
                  unit_b     <= req_b[int'(win)*32 +: 32];
                  unit_start <= 1'b1;
                  state      <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
`ifdef MULDIV_TIMEOUT_EN
               cnt   <= '0;
`endif
            end
            S_WAIT: begin
               if (unit_valid) begin
                  rsp_result       <= unit_result;
                  rsp_valid[owner] <= 1'b1;
                  state            <= S_RESP;
               end
`ifdef MULDIV_TIMEOUT_EN
               else if (cnt == 8'(TIMEOUT - 1)) begin
                  rsp_result       <= 32'hFFFF_FFFF;
                  rsp_err          <= 1'b1;
                  rsp_valid[owner] <= 1'b1;
                  state            <= S_RESP;
               end else begin
                  cnt <= cnt + 8'd1;
               end
`endif
            end
            S_RESP: begin
               ptr <= (owner == ID_W'(NUM_REQ - 1)) ? '0 : owner + ID_W'(1);
`ifdef MULDIV_TIMEOUT_EN
               // A timed-out op may still complete later; swallow that pulse in DRAIN.
               state   <= rsp_err ? S_DRAIN : S_IDLE;
               rsp_err <= 1'b0;
               cnt     <= '0;
`else
               state <= S_IDLE;
`endif
            end
`ifdef MULDIV_TIMEOUT_EN
            S_DRAIN: begin
               if (unit_valid || cnt == 8'(TIMEOUT - 1)) state <= S_IDLE;
               else                                       cnt   <= cnt + 8'd1;
            end
`endif
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_muldiv_share_arb.sv
// Directed + randomized bench for muldiv_share_arb with a behavioural round-robin/unit model.
module tb_muldiv_share_arb;
   localparam int N  = 2;
   localparam int TO = 64;

   logic                clk = 1'b0;
   logic                rst_n;
   logic [N-1:0]        req;
   logic [N-1:0][2:0]   op_q;
   logic [N-1:0][31:0]  a_q;
   logic [N-1:0][31:0]  b_q;
   logic [N-1:0]        req_ready;
   logic [N-1:0]        rsp_valid;
   logic [31:0]         rsp_result;
   logic                rsp_err;
   logic                busy;
   logic                unit_start;
   logic [2:0]          unit_op;
   logic [31:0]         unit_a;
   logic [31:0]         unit_b;
   logic                unit_valid;
   logic [31:0]         unit_result;

   int n_cmp = 0;
   int n_err = 0;
   int ptr_m = 0;

   always #5 clk = ~clk;

   muldiv_share_arb #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .req(req), .req_op(op_q), .req_a(a_q), .req_b(b_q),
      .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_result(rsp_result),
      .rsp_err(rsp_err), .busy(busy),
      .unit_start(unit_start), .unit_op(unit_op), .unit_a(unit_a), .unit_b(unit_b),
      .unit_valid(unit_valid), .unit_result(unit_result)
   );

   // What the external mul/div unit would compute.
   function automatic logic [31:0] unit_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (op == 3'd0) return a * b;
      return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
   endfunction

   function automatic logic [31:0] oh(input int w);
      logic [31:0] v;
      v    = '0;
      v[w] = 1'b1;
      return v;
   endfunction

   function automatic int pick();
      int j;
      for (int i = 0; i < N; i++) begin
         j = (ptr_m + i) % N;
         if (req[j]) return j;
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, "_start"}, 32'(unit_start), 32'd0);
      chk({tag, "_op"},    32'(unit_op),    32'd0);
      chk({tag, "_a"},     unit_a,          32'd0);
      chk({tag, "_b"},     unit_b,          32'd0);
      chk({tag, "_rspv"},  32'(rsp_valid),  32'd0);
      chk({tag, "_res"},   rsp_result,      32'd0);
      chk({tag, "_err"},   32'(rsp_err),    32'd0);
      chk({tag, "_busy"},  32'(busy),       32'd0);
   endtask

   // Called at a negedge with the DUT idle and req non-zero; runs one full op.
   task automatic serve(input int lat, input bit spur, input int pulse_id, input bit keep, output int w);
      logic [31:0] exp_r, ur;
      w = pick();
      #1;
      chk("grant", 32'(req_ready), oh(w));
      exp_r = unit_fn(op_q[w], a_q[w], b_q[w]);
      step();
      if (!keep) req[w] = 1'b0;
      chk("start", 32'(unit_start), 32'd1);
      chk("busy_issue", 32'(busy), 32'd1);
      chk("unit_op", 32'(unit_op), 32'(op_q[w]));
      chk("unit_a", unit_a, a_q[w]);
      chk("unit_b", unit_b, b_q[w]);
      ur = unit_fn(unit_op, unit_a, unit_b);
      if (spur) begin
         unit_valid  = 1'b1;
         unit_result = ~ur;
      end
      for (int k = 1; k <= lat; k++) begin
         #1 chk("ready_while_busy", 32'(req_ready), 32'd0);
         step();
         unit_valid  = (k == lat);
         unit_result = (k == lat) ? ur : $urandom();
         if (pulse_id >= 0) req[pulse_id] = (k == 1);
         chk("start_wait", 32'(unit_start), 32'd0);
         chk("rspv_wait", 32'(rsp_valid), 32'd0);
         chk("busy_wait", 32'(busy), 32'd1);
      end
      step();
      unit_valid = 1'b0;
      chk("rsp_valid", 32'(rsp_valid), oh(w));
      chk("rsp_result", rsp_result, exp_r);
      chk("rsp_err", 32'(rsp_err), 32'd0);
      chk("ready_resp", 32'(req_ready), 32'd0);
      ptr_m = (w + 1) % N;
      step();
      chk("rspv_after", 32'(rsp_valid), 32'd0);
      chk("busy_after", 32'(busy), 32'd0);
   endtask

   initial begin
      int w;
      rst_n = 1'b0; req = '0; op_q = '0; a_q = '0; b_q = '0;
      unit_valid = 1'b0; unit_result = '0;
      repeat (3) step();
      chk_idle_outs("reset");
      chk("reset_ready", 32'(req_ready), 32'd0);
      rst_n = 1'b1;
      step();

      // 7*6 on requester 0 with a 10-cycle unit
      op_q[0] = 3'd0; a_q[0] = 32'd7; b_q[0] = 32'd6; req = 2'b01;
      serve(10, 1'b0, -1, 1'b0, w);
      chk("t1_result", rsp_result, 32'd42);

      // reset in WAIT: pointer is 1 here and must return to 0
      op_q[1] = 3'd1; a_q[1] = 32'd99; b_q[1] = 32'd3; req = 2'b10;
      #1 chk("rst_grant", 32'(req_ready), 32'd2);
      step(); req = '0;
      step(); step();
      rst_n = 1'b0;
      repeat (3) step();
      chk_idle_outs("midrst");
      rst_n = 1'b1; unit_valid = 1'b1; unit_result = 32'h1234;
      step();
      unit_valid = 1'b0;
      chk("late_valid_rspv", 32'(rsp_valid), 32'd0);
      chk("late_valid_busy", 32'(busy), 32'd0);
      ptr_m = 0;

      // both requesters held, div 100/5: strict alternation from 0
      for (int i = 0; i < N; i++) begin op_q[i] = 3'd4; a_q[i] = 32'd100; b_q[i] = 32'd5; end
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         serve(3, 1'b0, -1, 1'b1, w);
         chk("t2_order", 32'(w), 32'(i % 2));
         chk("t2_result", rsp_result, 32'd20);
      end
      req = '0;
      step();

      // req0 pulsed while requester 1 is busy must never be granted
      op_q[1] = 3'd0; a_q[1] = 32'hFFFF_FFFF; b_q[1] = 32'd2; req = 2'b10;
      serve(5, 1'b0, 0, 1'b0, w);
      for (int i = 0; i < 4; i++) begin
         step();
         chk("t3_busy", 32'(busy), 32'd0);
         chk("t3_rspv", 32'(rsp_valid), 32'd0);
      end

      // spurious unit_valid in IDLE, then in ISSUE
      unit_valid = 1'b1; unit_result = 32'hDEAD;
      step();
      unit_valid = 1'b0;
      chk("t5_idle_rspv", 32'(rsp_valid), 32'd0);
      chk("t5_idle_busy", 32'(busy), 32'd0);
      op_q[0] = 3'd2; a_q[0] = 32'd1000; b_q[0] = 32'd0; req = 2'b01;
      serve(2, 1'b1, -1, 1'b0, w);

      for (int it = 0; it < 30; it++) begin
         if (req == '0) req = N'($urandom_range(1, (1 << N) - 1));
         for (int i = 0; i < N; i++) begin
            op_q[i] = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
            a_q[i]  = $urandom();
            b_q[i]  = ($urandom_range(0, 5) == 0) ? 32'd0 : ($urandom() >> $urandom_range(0, 28));
         end
         serve($urandom_range(1, 6), 1'($urandom_range(0, 1)), -1, 1'($urandom_range(0, 1)), w);
         if ($urandom_range(0, 3) == 0) begin
            req = '0; unit_valid = 1'b1;
            step();
            unit_valid = 1'b0;
            chk("rand_idle_rspv", 32'(rsp_valid), 32'd0);
            chk("rand_idle_busy", 32'(busy), 32'd0);
         end
      end
      req = '0;
      step();

`ifdef MULDIV_TIMEOUT_EN
      op_q[0] = 3'd0; a_q[0] = 32'd3; b_q[0] = 32'd3; req = 2'b01;
      w = pick();
      #1 chk("to_grant", 32'(req_ready), oh(w));
      step();
      req = '0;
      chk("to_start", 32'(unit_start), 32'd1);
      for (int k = 1; k <= TO; k++) begin
         step();
         chk("to_wait_rspv", 32'(rsp_valid), 32'd0);
      end
      step();
      chk("to_rspv", 32'(rsp_valid), oh(w));
      chk("to_err", 32'(rsp_err), 32'd1);
      chk("to_result", rsp_result, 32'hFFFF_FFFF);
      ptr_m = (w + 1) % N;
      step();
      chk("to_drain_busy", 32'(busy), 32'd1);
      unit_valid = 1'b1; unit_result = 32'd9;
      step();
      unit_valid = 1'b0;
      chk("to_drop_rspv", 32'(rsp_valid), 32'd0);
      chk("to_drop_busy", 32'(busy), 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
